// File: rtl/ef_dac_stream_ctrl.sv
// Sequencer for DACSCA R-string/cap DACs: FIFO-buffered codes, one commit pulse per
// sample period on DAC_RST (DAC latches SELD on the RST falling edge), stream or loop playback.
module ef_dac_stream_ctrl #(
    parameter int DW     = 10,
    parameter int DEPTH  = 16,
    parameter int CW     = 16,
    parameter int SETTLE = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_en,
    input  logic                       i_mode,
    input  logic [CW-1:0]              i_period,
    input  logic [DW-1:0]              i_wdata,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    input  logic                       i_flush,
    input  logic                       i_ufl_clr,
    output logic                       o_dac_en,
    output logic                       o_dac_rst,
    output logic [DW-1:0]              o_dac_sel,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN} state_t;

    state_t          r_state;
    logic [SW-1:0]   r_settle_cnt;
    logic [CW-1:0]   r_tick_cnt;
    logic            r_dac_en;
    logic            r_dac_rst;
    logic [DW-1:0]   r_dac_sel;
    logic            r_underflow;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_play_ptr;
    logic            r_play_vld;
    logic [LW-1:0]   r_level;

    logic [CW-1:0]   w_reload;
    logic            w_run;
    logic            w_tick;
    logic            w_fifo_empty;
    logic            w_commit;
    logic            w_pop;
    logic            w_loop_adv;
    logic            w_wr;
    logic [AW-1:0]   w_play_src;
    logic [AW-1:0]   w_play_inc;
    logic [AW-1:0]   w_play_nxt;
    logic [DW-1:0]   w_code;

    // A programmed period of 0 is treated as 1 so that ticks are never back to back.
    assign w_reload     = (i_period == '0) ? CW'(1) : i_period;
    assign w_run        = (r_state == S_RUN);
    assign w_tick       = w_run & i_en & (r_tick_cnt == '0);
    assign w_fifo_empty = (r_level == '0) | i_flush;
    assign w_commit     = w_tick & ~w_fifo_empty;
    assign w_pop        = w_commit & ~i_mode;
    assign w_loop_adv   = w_commit & i_mode;

    // Loop playback begins at the head until the play pointer has been advanced once.
    assign w_play_src   = r_play_vld ? r_play_ptr : r_rd_ptr;
    assign w_play_inc   = w_play_src + AW'(1);
    assign w_play_nxt   = (w_play_inc == r_wr_ptr) ? r_rd_ptr : w_play_inc;
    assign w_code       = i_mode ? r_mem[w_play_src] : r_mem[r_rd_ptr];

    assign o_wready     = ~o_full & ~(i_mode & w_run);
    assign w_wr         = i_wvalid & o_wready;

    assign o_full       = (r_level == LW'(DEPTH));
    assign o_empty      = (r_level == '0);
    assign o_level      = r_level;
    assign o_dac_en     = r_dac_en;
    assign o_dac_rst    = r_dac_rst;
    assign o_dac_sel    = r_dac_sel;
    assign o_underflow  = r_underflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_tick_cnt   <= '0;
            r_dac_en     <= 1'b0;
            r_dac_rst    <= 1'b0;
            r_dac_sel    <= '0;
        end else if (!i_en) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_tick_cnt   <= '0;
            r_dac_en     <= 1'b0;
            r_dac_rst    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state      <= S_SETTLE;
                    r_dac_en     <= 1'b1;
                    r_settle_cnt <= '0;
                    r_dac_rst    <= 1'b0;
                end
                S_SETTLE: begin
                    r_dac_rst <= 1'b0;
                    if (r_settle_cnt == SW'(SETTLE - 1)) begin
                        r_state    <= S_RUN;
                        r_tick_cnt <= w_reload;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SW'(1);
                    end
                end
                S_RUN: begin
                    r_tick_cnt <= (r_tick_cnt == '0) ? w_reload : r_tick_cnt - CW'(1);
                    // RST is high for exactly the cycle after a committing tick.
                    r_dac_rst  <= w_commit;
                    if (w_commit) begin
                        r_dac_sel <= w_code;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_dac_en  <= 1'b0;
                    r_dac_rst <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_play_ptr <= '0;
            r_play_vld <= 1'b0;
            r_level    <= '0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_play_ptr <= '0;
            r_play_vld <= 1'b0;
            r_level    <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (!w_run || !i_en || (w_tick && !i_mode)) begin
                r_play_vld <= 1'b0;
            end else if (w_loop_adv) begin
                r_play_vld <= 1'b1;
                r_play_ptr <= w_play_nxt;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_underflow <= 1'b0;
        end else if (w_tick && w_fifo_empty) begin
            r_underflow <= 1'b1;
        end else if (i_ufl_clr) begin
            r_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ef_dac_stream_ctrl.sv
// Bench for ef_dac_stream_ctrl: scoreboard of expected committed codes plus
// a write-side vector table and hand-built timing sequences.
module tb_ef_dac_stream_ctrl;
    localparam int DW = 10, DEPTH = 16, CW = 16, SETTLE = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, mode = 1'b0, wvalid = 1'b0, flush = 1'b0, ufl_clr = 1'b0;
    logic [CW-1:0] period = '0;
    logic [DW-1:0] wdata = '0;
    logic          wready, dac_en, dac_rst, full, empty, underflow;
    logic [DW-1:0] dac_sel;
    logic [4:0]    level;

    ef_dac_stream_ctrl #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .SETTLE(SETTLE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_period(period),
        .i_wdata(wdata), .i_wvalid(wvalid), .o_wready(wready), .i_flush(flush),
        .i_ufl_clr(ufl_clr), .o_dac_en(dac_en), .o_dac_rst(dac_rst), .o_dac_sel(dac_sel),
        .o_level(level), .o_full(full), .o_empty(empty), .o_underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int t_en = 0;
    int rise_q[$];
    logic [DW-1:0] exp_q[$];
    logic prev_rst = 1'b0, prev_en = 1'b0;

    typedef struct {
        logic [DW-1:0] wdata;
        logic          exp_wready;
        logic [4:0]    exp_level;
        logic          exp_full;
    } vec_t;
    vec_t tbl[17];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every rising DAC_RST must carry the next expected code.
    always @(negedge clk) begin
        if (dac_en && !prev_en) t_en = cyc;
        if (dac_rst && !prev_rst) begin
            rise_q.push_back(cyc);
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pulse_unexpected: got sel %0h expected no pulse", dac_sel);
            end else begin
                check("pulse_code", dac_sel, exp_q.pop_front());
            end
        end
        if (prev_rst && dac_rst) check("pulse_width", 2, 1);
        prev_rst = dac_rst;
        prev_en  = dac_en;
    end

    task automatic wr(input logic [DW-1:0] code, input bit push);
        wdata  = code;
        wvalid = 1'b1;
        #1;
        if (wready && push) exp_q.push_back(code);
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int n = 0;
        while (pulse_cnt < target && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (pulse_cnt < target) check("pulse_timeout", pulse_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 17; i++) begin
            tbl[i].wdata      = DW'(i * 37 + 5);
            tbl[i].exp_wready = (i < 16);
            tbl[i].exp_level  = (i < 16) ? 5'(i + 1) : 5'd16;
            tbl[i].exp_full   = (i >= 15);
        end

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_dac_en", dac_en, 0);
        check("rst_dac_rst", dac_rst, 0);
        check("rst_dac_sel", dac_sel, 0);
        check("rst_underflow", underflow, 0);
        check("rst_level", level, 0);
        check("rst_wready", wready, 1);
        check("rst_empty", empty, 1);
        rst_n = 1'b1;

        // Streaming three codes at PERIOD=3
        @(negedge clk);
        en = 1'b1; mode = 1'b0; period = 16'd3;
        wr(10'h001, 1);
        check("t1_dac_en_at_once", dac_en, 1);
        wr(10'h155, 1);
        wr(10'h3FF, 1);
        #1 check("t1_level3", level, 3);
        wait_pulses(3, 60);
        check("t1_first_pulse", rise_q[0] - t_en, SETTLE + 4);
        check("t1_gap1", rise_q[1] - rise_q[0], 4);
        check("t1_gap2", rise_q[2] - rise_q[1], 4);
        check("t1_level0", level, 0);

        // Underflow after the buffer drains, then clear
        repeat (6) @(negedge clk);
        #2;
        check("t2_underflow", underflow, 1);
        check("t2_no_4th_pulse", pulse_cnt, 3);
        check("t2_sel_hold", dac_sel, 10'h3FF);
        en = 1'b0;
        repeat (2) @(negedge clk);
        ufl_clr = 1'b1;
        @(negedge clk);
        ufl_clr = 1'b0;
        #1;
        check("t2_ufl_clr", underflow, 0);
        check("t2_idle_dac_en", dac_en, 0);
        check("t2_idle_sel", dac_sel, 10'h3FF);

        // Fill to FULL from the vector table, 17th write refused, then FLUSH
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            wdata  = tbl[i].wdata;
            wvalid = 1'b1;
            #1 check($sformatf("t3_wready_%0d", i), wready, tbl[i].exp_wready);
            @(negedge clk);
            wvalid = 1'b0;
            #1;
            check($sformatf("t3_level_%0d", i), level, tbl[i].exp_level);
            check($sformatf("t3_full_%0d", i), full, tbl[i].exp_full);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("t3_flush_level", level, 0);
        check("t3_flush_empty", empty, 1);
        check("t3_flush_wready", wready, 1);

        // Loop playback then switch back to streaming
        @(negedge clk);
        wr(10'h0A1, 0);
        wr(10'h1B2, 0);
        wr(10'h2C3, 0);
        wr(10'h3D4, 0);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(10'h0A1);
            exp_q.push_back(10'h1B2);
            exp_q.push_back(10'h2C3);
            exp_q.push_back(10'h3D4);
        end
        mode = 1'b1;
        en   = 1'b1;
        wait_pulses(3 + 5, 120);
        check("t4_loop_level", level, 4);
        check("t4_loop_wready", wready, 0);
        wait_pulses(3 + 8, 60);
        mode = 1'b0;
        wait_pulses(3 + 12, 60);
        check("t4_ufl_before_drain", underflow, 0);
        repeat (6) @(negedge clk);
        #2;
        check("t4_underflow", underflow, 1);
        check("t4_level_drained", level, 0);
        check("t4_pulse_total", pulse_cnt, 15);

        // PERIOD=0 gives 2-clock spacing; a mid-run change waits for the next reload
        en = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; period = 16'd0;
        for (int i = 0; i < 6; i++) wr(DW'(10'h040 + i * 3), 1);
        en = 1'b1;
        base = pulse_cnt;
        wait_pulses(base + 2, 80);
        period = 16'd5;
        wait_pulses(base + 4, 60);
        check("t5_gap_p0_a", rise_q[base + 1] - rise_q[base], 2);
        check("t5_gap_p0_b", rise_q[base + 2] - rise_q[base + 1], 2);
        check("t5_gap_p5", rise_q[base + 3] - rise_q[base + 2], 6);

        // Drop EN while DAC_RST is high, then resume from the next head code
        check("t6_rst_high", dac_rst, 1);
        en = 1'b0;
        @(negedge clk);
        #1;
        check("t6_rst_dropped", dac_rst, 0);
        check("t6_en_dropped", dac_en, 0);
        check("t6_level_kept", level, 2);
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_pulses(base + 6, 80);
        check("t6_resume_first", rise_q[base + 4] - t_en, SETTLE + 6);
        check("t6_scoreboard_empty", exp_q.size(), 0);
        check("t6_level_end", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
